// File: rtl/router_pkg.sv
// Shared router definitions: sizing constants, the per-VC state encoding,
// and a grant decoder that returns the lowest set grant bit.
package router_pkg;

    localparam int NO_OF_REQS = 15;
    localparam int NUM_VCS    = 2;
    localparam int BUF_DEPTH  = 4;
    localparam int OWNER_W    = $clog2(NO_OF_REQS);
    localparam int CNT_W      = $clog2(BUF_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        VC_IDLE   = 2'd0,
        VC_ACTIVE = 2'd1,
        VC_DRAIN  = 2'd2
    } vc_state_t;

    typedef struct packed {
        logic [OWNER_W-1:0] idx;
        logic               multi;
    } grant_dec_t;

    // Lowest set bit wins; multi flags a grant vector that is not one-hot.
    function automatic grant_dec_t decode_grant(input logic [NO_OF_REQS-1:0] g);
        grant_dec_t r;
        r.idx   = '0;
        r.multi = |(g & (g - {{(NO_OF_REQS-1){1'b0}}, 1'b1}));
        for (int i = NO_OF_REQS - 1; i >= 0; i--) begin
            if (g[i]) r.idx = OWNER_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/router_ovc_slot.sv
// One output VC: allocation FSM, owner register and downstream credit counter.
// OVC_ATOMIC_REALLOC_EN holds the VC in DRAIN after the tail until all credits return.
module router_ovc_slot
    import router_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [NO_OF_REQS-1:0] Grant,
    input  logic                  Send,
    input  logic                  Send_tail,
    input  logic                  Credit_ret,
    output logic                  Busy,
    output logic [OWNER_W-1:0]    Owner,
    output logic [CNT_W-1:0]      Cnt,
    output logic                  Err
);

    vc_state_t          state, state_nxt;
    logic [OWNER_W-1:0] owner_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               err_nxt;
    grant_dec_t         dec;

    always_ff @(posedge Clk) begin
        if (!Rst) state <= VC_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            Owner <= '0;
            Cnt   <= CNT_FULL;
            Err   <= 1'b0;
        end else begin
            Owner <= owner_nxt;
            Cnt   <= cnt_nxt;
            Err   <= err_nxt;
        end
    end

    always_comb begin
        dec       = decode_grant(Grant);
        state_nxt = state;
        owner_nxt = Owner;
        cnt_nxt   = Cnt;
        err_nxt   = Err;

        // Grants are only looked at in IDLE; a held grant while ACTIVE is normal.
        case (state)
            VC_IDLE: begin
                if (Send) err_nxt = 1'b1;
                if (|Grant) begin
                    state_nxt = VC_ACTIVE;
                    owner_nxt = dec.idx;
                    if (dec.multi) err_nxt = 1'b1;
                end
            end
            VC_ACTIVE: begin
                if (Send && Send_tail) begin
`ifdef OVC_ATOMIC_REALLOC_EN
                    state_nxt = VC_DRAIN;
`else
                    state_nxt = VC_IDLE;
`endif
                end
            end
            VC_DRAIN: begin
                if (Send) err_nxt = 1'b1;
                if (Cnt == CNT_FULL) state_nxt = VC_IDLE;
            end
            default: state_nxt = VC_IDLE;
        endcase

        // Send and return together cancel; saturate and flag at either end.
        if (Send && !Credit_ret) begin
            if (Cnt == '0) err_nxt = 1'b1;
            else           cnt_nxt = Cnt - 1'b1;
        end else if (Credit_ret && !Send) begin
            if (Cnt == CNT_FULL) err_nxt = 1'b1;
            else                 cnt_nxt = Cnt + 1'b1;
        end
    end

    assign Busy = (state != VC_IDLE);

endmodule

// File: rtl/router_ovc_state.sv
// Output-port VC state tracker: two VC slots fed by the VC arbiter grants.
// Define OVC_ATOMIC_REALLOC_EN for atomic (drain-before-reuse) reallocation.
module router_ovc_state
    import router_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [NO_OF_REQS-1:0] Port_vc0_arb_grant,
    input  logic [NO_OF_REQS-1:0] Port_vc1_arb_grant,
    input  logic                  Flit_send_valid,
    input  logic                  Flit_send_vc,
    input  logic                  Flit_send_tail,
    input  logic                  Credit_in_valid,
    input  logic                  Credit_in_vc,
    output logic [NUM_VCS-1:0]    Vc_busy,
    output logic [OWNER_W-1:0]    Vc0_owner,
    output logic [OWNER_W-1:0]    Vc1_owner,
    output logic [NUM_VCS-1:0]    Credit_avail,
    output logic [CNT_W-1:0]      Credit_cnt0,
    output logic [CNT_W-1:0]      Credit_cnt1,
    output logic                  Err
);

    logic send0, send1, ret0, ret1;
    logic err0, err1;

    assign send0 = Flit_send_valid && !Flit_send_vc;
    assign send1 = Flit_send_valid &&  Flit_send_vc;
    assign ret0  = Credit_in_valid && !Credit_in_vc;
    assign ret1  = Credit_in_valid &&  Credit_in_vc;

    router_ovc_slot u_slot0 (
        .Clk        (Clk),
        .Rst        (Rst),
        .Grant      (Port_vc0_arb_grant),
        .Send       (send0),
        .Send_tail  (Flit_send_tail),
        .Credit_ret (ret0),
        .Busy       (Vc_busy[0]),
        .Owner      (Vc0_owner),
        .Cnt        (Credit_cnt0),
        .Err        (err0)
    );

    router_ovc_slot u_slot1 (
        .Clk        (Clk),
        .Rst        (Rst),
        .Grant      (Port_vc1_arb_grant),
        .Send       (send1),
        .Send_tail  (Flit_send_tail),
        .Credit_ret (ret1),
        .Busy       (Vc_busy[1]),
        .Owner      (Vc1_owner),
        .Cnt        (Credit_cnt1),
        .Err        (err1)
    );

    assign Credit_avail = {|Credit_cnt1, |Credit_cnt0};
    assign Err          = err0 | err1;

endmodule
